// File: rtl/obi_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : obi_sram_responder                                         |
// | Description : OBI-style responder (req/gnt/rvalid/err) in front of a     |
// |               synchronous single-port SRAM macro. Requests are granted   |
// |               after WaitCycles idle cycles, turned into single-cycle     |
// |               SRAM accesses and answered exactly one cycle after grant.  |
// |               Out-of-range or empty-byte-enable requests get a bus       |
// |               error response carrying ErrData.                           |
// | Ports       : clk_i/rst_ni   clock, async active-low reset               |
// |               req_i..wdata_i initiator request (held stable until gnt_o) |
// |               gnt_o          request accepted this cycle                 |
// |               rvalid_o/rdata_o/err_o  response, one cycle after gnt_o    |
// |               sram_*         SRAM macro access port                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module obi_sram_responder #(
    parameter logic [31:0] BaseAddr   = 32'h1000_0000,
    parameter int          NumWords   = 512,
    parameter int          WaitCycles = 0,
    parameter logic [31:0] ErrData    = 32'hBADC_AB1E,
    localparam int         c_ADDR_W   = $clog2(NumWords)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    output logic                sram_req_o,
    output logic                sram_we_o,
    output logic [3:0]          sram_be_o,
    output logic [c_ADDR_W-1:0] sram_addr_o,
    output logic [31:0]         sram_wdata_o,
    input  logic [31:0]         sram_rdata_i
);

    localparam logic [0:0]  c_S_IDLE = 1'b0;
    localparam logic [0:0]  c_S_WAIT = 1'b1;
    localparam logic [3:0]  c_WAIT   = 4'(WaitCycles);
    // 33-bit bounds so BaseAddr + 4*NumWords cannot wrap past 2^32.
    localparam logic [32:0] c_LO     = {1'b0, BaseAddr};
    localparam logic [32:0] c_HI     = c_LO + 33'(4 * NumWords);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_gnt;
    logic                w_in_range;
    logic                w_access;
    logic [c_ADDR_W-1:0] w_word;
    logic [1:0]          w_unused_lsb;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic                r_resp_is_read;

    // Only the low address bits influence the word index, so the subtraction
    // is done at that width; the two byte-offset bits are dropped.
    assign {w_word, w_unused_lsb} = addr_i[c_ADDR_W+1:0] - BaseAddr[c_ADDR_W+1:0];
    assign w_in_range = ({1'b0, addr_i} >= c_LO) && ({1'b0, addr_i} < c_HI);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (req_i && (c_WAIT != 4'd0)) begin
                    w_state_nxt = c_S_WAIT;
                    w_cnt_nxt   = 4'd1;
                end
            end
            c_S_WAIT: begin
                // A dropped request aborts the wait without any response.
                if (!req_i || (r_cnt == c_WAIT)) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_gnt = 1'b0;
        case (r_state)
            c_S_IDLE: w_gnt = req_i && (c_WAIT == 4'd0);
            c_S_WAIT: w_gnt = req_i && (r_cnt == c_WAIT);
            default:  w_gnt = 1'b0;
        endcase
        // Grant is combinational from req_i; keep it (and the SRAM strobe)
        // quiet while reset is held.
        w_gnt    = w_gnt && rst_ni;
        w_access = w_gnt && w_in_range && (be_i != 4'd0);

        gnt_o        = w_gnt;
        sram_req_o   = w_access;
        sram_we_o    = w_access ? we_i    : 1'b0;
        sram_be_o    = w_access ? be_i    : 4'd0;
        sram_addr_o  = w_access ? w_word  : '0;
        sram_wdata_o = w_access ? wdata_i : 32'd0;
    end

    // ---------------- response stage (fixed latency 1) ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_valid   <= 1'b0;
            r_resp_err     <= 1'b0;
            r_resp_is_read <= 1'b0;
        end else begin
            r_resp_valid   <= w_gnt;
            r_resp_err     <= w_gnt && !w_access;
            r_resp_is_read <= w_access && !we_i;
        end
    end

    always_comb begin
        rvalid_o = r_resp_valid;
        err_o    = r_resp_valid && r_resp_err;
        rdata_o  = 32'd0;
        if (r_resp_valid) begin
            if (r_resp_err) begin
                rdata_o = ErrData;
            end else if (r_resp_is_read) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_obi_sram_responder                                      |
// | Description : Self-checking bench for obi_sram_responder. Instance A     |
// |               runs with no wait states, instance B with three. Each has  |
// |               its own behavioural SRAM; expected responses come from a   |
// |               word-array reference model of the bus address space.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_obi_sram_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NW   = 512;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // instance A (WaitCycles = 0)
    logic        req_a = 0, we_a = 0, gnt_a, rvalid_a, err_a;
    logic [3:0]  be_a = 0;
    logic [31:0] addr_a = 0, wdata_a = 0, rdata_a;
    logic        sreq_a, swe_a;
    logic [3:0]  sbe_a;
    logic [8:0]  saddr_a;
    logic [31:0] swdata_a, srdata_a;
    // instance B (WaitCycles = 3)
    logic        req_b = 0, we_b = 0, gnt_b, rvalid_b, err_b;
    logic [3:0]  be_b = 0;
    logic [31:0] addr_b = 0, wdata_b = 0, rdata_b;
    logic        sreq_b, swe_b;
    logic [3:0]  sbe_b;
    logic [8:0]  saddr_b;
    logic [31:0] swdata_b, srdata_b;

    obi_sram_responder #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(0), .ErrData(ERRD)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_a), .gnt_o(gnt_a), .we_i(we_a), .be_i(be_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
        .sram_req_o(sreq_a), .sram_we_o(swe_a), .sram_be_o(sbe_a), .sram_addr_o(saddr_a),
        .sram_wdata_o(swdata_a), .sram_rdata_i(srdata_a));

    obi_sram_responder #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(3), .ErrData(ERRD)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b), .be_i(be_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
        .sram_req_o(sreq_b), .sram_we_o(swe_b), .sram_be_o(sbe_b), .sram_addr_o(saddr_b),
        .sram_wdata_o(swdata_b), .sram_rdata_i(srdata_b));

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [31:0] seed(input int i, input int k);
        return (32'(i) * 32'h0101_0107) ^ ((k != 0) ? 32'h5A5A_0000 : 32'hA5A5_1234);
    endfunction

    // ---------------- behavioural SRAM macros ----------------
    bit          init_mem = 1'b1;
    logic [31:0] mem_a [NW];
    logic [31:0] mem_b [NW];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NW; i++) mem_a[i] <= seed(i, 0);
        end else if (sreq_a) begin
            if (swe_a) begin
                for (int k = 0; k < 4; k++)
                    if (sbe_a[k]) mem_a[saddr_a][k*8 +: 8] <= swdata_a[k*8 +: 8];
            end else begin
                srdata_a <= mem_a[saddr_a];
            end
        end
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int j = 0; j < NW; j++) mem_b[j] <= seed(j, 1);
        end else if (sreq_b) begin
            if (swe_b) begin
                for (int m = 0; m < 4; m++)
                    if (sbe_b[m]) mem_b[saddr_b][m*8 +: 8] <= swdata_b[m*8 +: 8];
            end else begin
                srdata_b <= mem_b[saddr_b];
            end
        end
    end

    // ---------------- reference model: bus address space as word array ----------------
    logic [31:0] ref_a [NW];
    logic [31:0] ref_b [NW];

    task automatic ref_access(input bit sel, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d,
                              output bit acc, output logic [8:0] ix,
                              output bit er, output logic [31:0] rd);
        logic [63:0] la;
        logic [31:0] word;
        la  = {32'd0, a};
        acc = (la >= {32'd0, BASE}) && (la < {32'd0, BASE} + 64'(4 * NW)) && (b != 4'd0);
        ix  = 9'((a - BASE) / 4);
        er  = !acc;
        rd  = 32'd0;
        if (er) begin
            rd = ERRD;
        end else begin
            word = sel ? ref_b[ix] : ref_a[ix];
            if (w) begin
                for (int k = 0; k < 4; k++) if (b[k]) word[k*8 +: 8] = d[k*8 +: 8];
                if (sel) ref_b[ix] = word; else ref_a[ix] = word;
            end else begin
                rd = word;
            end
        end
    endtask

    // ---------------- instance A: one cycle of stimulus plus checks ----------------
    bit          pend_a = 0;
    bit          pend_err_a = 0;
    logic [31:0] pend_rd_a = 0;

    task automatic step_a(input bit r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        bit acc, er;
        logic [8:0] ix;
        logic [31:0] rd;
        logic [33:0] exp_r;
        logic [46:0] exp_s;
        @(posedge clk); #1;
        req_a = r; we_a = w; be_a = b; addr_a = a; wdata_a = d;
        @(negedge clk);
        exp_r = pend_a ? {1'b1, pend_err_a, pend_rd_a} : 34'd0;
        n_cmp++;
        if ({rvalid_a, err_a, rdata_a} !== exp_r) begin
            n_fail++;
            $display("FAIL a_resp @%0t: {rvalid,err,rdata} got %h expected %h", $time,
                     {rvalid_a, err_a, rdata_a}, exp_r);
        end
        n_cmp++;
        if (gnt_a !== r) begin
            n_fail++;
            $display("FAIL a_gnt @%0t: got %b expected %b", $time, gnt_a, r);
        end
        acc = 0; er = 0; ix = '0; rd = '0;
        if (r) ref_access(1'b0, w, b, a, d, acc, ix, er, rd);
        exp_s = acc ? {1'b1, w, b, ix, d} : 47'd0;
        n_cmp++;
        if ({sreq_a, swe_a, sbe_a, saddr_a, swdata_a} !== exp_s) begin
            n_fail++;
            $display("FAIL a_sram @%0t: {req,we,be,addr,wdata} got %h expected %h", $time,
                     {sreq_a, swe_a, sbe_a, saddr_a, swdata_a}, exp_s);
        end
        pend_a = r; pend_err_a = er; pend_rd_a = rd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        req_a = 1; we_a = 0; be_a = 4'hF; addr_a = BASE;
        req_b = 1; we_b = 0; be_b = 4'hF; addr_b = BASE;
        #2;
        n_cmp++;
        if ({gnt_a, rvalid_a, err_a, rdata_a, sreq_a} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_a: {gnt,rvalid,err,rdata,sram_req} got %h expected 0",
                     {gnt_a, rvalid_a, err_a, rdata_a, sreq_a});
        end
        @(posedge clk); #1; init_mem = 0;
        @(negedge clk);
        n_cmp++;
        if ({gnt_b, rvalid_b, err_b, rdata_b, sreq_b, gnt_a, sreq_a} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_hold: {gnt_b,rvalid_b,err_b,rdata_b,sreq_b,gnt_a,sreq_a} got %h expected 0",
                     {gnt_b, rvalid_b, err_b, rdata_b, sreq_b, gnt_a, sreq_a});
        end
        @(posedge clk); #1;
        req_a = 0; req_b = 0; rst_ni = 1;
    endtask

    task automatic test_write_read;
        step_a(1, 1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
        step_a(1, 0, 4'hF, BASE + 32'h10, 32'h0);
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_byte_write;
        step_a(1, 1, 4'hF,    BASE + 32'h24, 32'h1122_3344);
        step_a(1, 1, 4'b0010, BASE + 32'h24, 32'h0000_AB00);
        step_a(1, 0, 4'hF,    BASE + 32'h24, 32'h0);
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_out_of_range;
        step_a(1, 0, 4'hF, BASE + 32'h800, 32'h0);
        step_a(1, 0, 4'hF, 32'h0FFF_FFFC, 32'h0);
        step_a(1, 0, 4'hF, BASE + 32'h7FC, 32'h0);
        step_a(1, 1, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678);
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_empty_be;
        step_a(1, 1, 4'h0, BASE + 32'h30, 32'h1234_5678);
        step_a(1, 0, 4'hF, BASE + 32'h30, 32'h0);
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'(($urandom_range(1, 64)) * 4);
            1:       return BASE + 32'h800 + 32'($urandom_range(0, 255) * 4);
            2:       return $urandom;
            3:       return 32'hFFFF_FFFC;
            default: return BASE + 32'($urandom_range(0, NW - 1) * 4) + 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic test_back_to_back_random;
        for (int i = 0; i < 80; i++) begin
            step_a(($urandom_range(0, 4) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
                   rand_addr(), $urandom);
        end
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_wait_states;
        logic        we_l [3];
        logic [31:0] ad_l [3];
        bit          pend, perr, acc, er;
        logic [31:0] prd, rd;
        logic [8:0]  ix;
        logic [33:0] exp_r;
        we_l[0] = 1; we_l[1] = 0; we_l[2] = 0;
        ad_l[0] = BASE + 32'h20; ad_l[1] = BASE + 32'h20; ad_l[2] = BASE + 32'h1FC;
        pend = 0; perr = 0; prd = 0;
        // req held high across three back-to-back transfers
        for (int t = 0; t < 3; t++) begin
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk); #1;
                if (c == 1) begin
                    req_b = 1; we_b = we_l[t]; be_b = 4'hF; addr_b = ad_l[t];
                    wdata_b = 32'hCAFE_F00D;
                end
                @(negedge clk);
                n_cmp++;
                if (gnt_b !== (c == 4)) begin
                    n_fail++;
                    $display("FAIL b_gnt t%0d c%0d: got %b expected %b", t, c, gnt_b, (c == 4));
                end
                exp_r = (c == 1 && pend) ? {1'b1, perr, prd} : 34'd0;
                n_cmp++;
                if ({rvalid_b, err_b, rdata_b} !== exp_r) begin
                    n_fail++;
                    $display("FAIL b_resp t%0d c%0d: got %h expected %h", t, c,
                             {rvalid_b, err_b, rdata_b}, exp_r);
                end
                if (c == 4) begin
                    ref_access(1'b1, we_l[t], 4'hF, ad_l[t], 32'hCAFE_F00D, acc, ix, er, rd);
                    n_cmp++;
                    if ({sreq_b, swe_b, saddr_b} !== {acc, we_l[t], ix}) begin
                        n_fail++;
                        $display("FAIL b_sram t%0d: {req,we,addr} got %h expected %h", t,
                                 {sreq_b, swe_b, saddr_b}, {acc, we_l[t], ix});
                    end
                    pend = 1; perr = er; prd = rd;
                end else begin
                    n_cmp++;
                    if (sreq_b !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b_sram_idle t%0d c%0d: got %b expected 0", t, c, sreq_b);
                    end
                end
            end
        end
        @(posedge clk); #1; req_b = 0;
        @(negedge clk);
        n_cmp++;
        if ({rvalid_b, err_b, rdata_b} !== {1'b1, perr, prd}) begin
            n_fail++;
            $display("FAIL b_resp_last: got %h expected %h", {rvalid_b, err_b, rdata_b}, {1'b1, perr, prd});
        end
        // aborted request: two cycles of req then a drop -> no grant, no response
        @(posedge clk); #1; req_b = 1; we_b = 0; addr_b = BASE + 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #1; req_b = 0;
        @(negedge clk);
        n_cmp++;
        if ({gnt_b, rvalid_b, sreq_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL b_abort: {gnt,rvalid,sram_req} got %b expected 000", {gnt_b, rvalid_b, sreq_b});
        end
        // a fresh request must again wait the full three cycles
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            req_b = (c <= 4);
            @(negedge clk);
            n_cmp++;
            if ({gnt_b, rvalid_b} !== {(c == 4), (c == 5)}) begin
                n_fail++;
                $display("FAIL b_retry c%0d: {gnt,rvalid} got %b expected %b", c,
                         {gnt_b, rvalid_b}, {(c == 4), (c == 5)});
            end
        end
        ref_access(1'b1, 1'b0, 4'hF, BASE + 32'h20, 32'h0, acc, ix, er, rd);
        n_cmp++;
        if ({err_b, rdata_b} !== {1'b0, rd}) begin
            n_fail++;
            $display("FAIL b_retry_data: got %h expected %h", {err_b, rdata_b}, {1'b0, rd});
        end
    endtask

    task automatic test_reset_mid;
        step_a(1, 0, 4'hF, BASE + 32'h40, 32'h0);
        @(posedge clk); #1;
        rst_ni = 0;
        req_a = 1; we_a = 1; be_a = 4'hF; addr_a = BASE + 32'h40; wdata_a = 32'hFFFF_0000;
        #1;
        n_cmp++;
        if ({rvalid_a, err_a, rdata_a, gnt_a} !== 35'd0) begin
            n_fail++;
            $display("FAIL mid_reset_resp: {rvalid,err,rdata,gnt} got %h expected 0",
                     {rvalid_a, err_a, rdata_a, gnt_a});
        end
        @(negedge clk);
        n_cmp++;
        if ({sreq_a, swe_a, sbe_a, saddr_a, swdata_a} !== 47'd0) begin
            n_fail++;
            $display("FAIL mid_reset_sram: got %h expected 0", {sreq_a, swe_a, sbe_a, saddr_a, swdata_a});
        end
        @(posedge clk); #1;
        rst_ni = 1; req_a = 0;
        pend_a = 0;
        step_a(1, 0, 4'hF, BASE + 32'h40, 32'h0);
        step_a(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            ref_a[i] = seed(i, 0);
            ref_b[i] = seed(i, 1);
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_out_of_range();
        test_empty_be();
        test_back_to_back_random();
        test_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_sram_responder.md
Name: obi_sram_responder

Overview:
- Subordinate (responder) end of the core's instruction/data memory protocol (req/gnt/rvalid/err).
- Accepts word-aligned OBI-style requests from the core wrapper's instruction or data port.
- Converts them into single-cycle accesses on a synchronous single-port SRAM macro.
- Returns read data/error one cycle after the access. Supports a configurable number of grant wait states and flags out-of-range or empty-byte-enable accesses as bus errors.

Parameters:
- BaseAddr, 32'h1000_0000, byte address of SRAM word 0.
- NumWords, 512, SRAM depth in 32-bit words (power of two, >=2).
- WaitCycles, 0, idle cycles inserted between the first cycle of req_i and gnt_o (0..15).
- ErrData, 32'hBADC_AB1E, rdata_o value returned with err_o.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  1  request valid from initiator
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1=write, 0=read
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid (exactly one per grant)
- rdata_o  out  32  read data
- err_o  out  1  response error, valid with rvalid_o
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  SRAM write enable
- sram_be_o  out  4  SRAM byte enables
- sram_addr_o  out  $clog2(NumWords)  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid the cycle after sram_req_o

Behaviour:
- Reset (rst_ni low, async): state=IDLE, wait counter=0, rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, sram_req_o=0.
- States: IDLE, WAIT. The response stage is a separate one-deep register (resp_valid, resp_err, resp_is_read).
- IDLE:
  - If req_i and WaitCycles==0: gnt_o=1 combinationally in the same cycle.
  - If req_i and WaitCycles>0: go to WAIT with counter=1, gnt_o=0.
- WAIT:
  - If req_i and counter==WaitCycles: gnt_o=1, return to IDLE, counter=0.
  - If req_i and counter<WaitCycles: counter++.
  - If req_i drops (protocol violation): return to IDLE, counter=0, no response.
- Initiator must hold we_i/be_i/addr_i/wdata_i stable from req_i rise to gnt_o. The block does not register them before the grant.
- Range check, evaluated in the grant cycle:
  - in_range = addr_i >= BaseAddr && addr_i < BaseAddr + 4*NumWords, using 33-bit arithmetic so the upper bound cannot wrap.
  - addr_i[1:0] is ignored.
- Grant cycle, in_range && be_i!=0:
  - sram_req_o=1, sram_we_o=we_i, sram_be_o=be_i.
  - sram_addr_o=(addr_i-BaseAddr)>>2, truncated to the address width.
  - sram_wdata_o=wdata_i.
- Grant cycle, otherwise: sram_req_o=0; the response is flagged as an error.
- sram_req_o is never asserted outside a grant cycle. sram_we_o/be_o/addr_o/wdata_o are don't-care when sram_req_o=0, but are driven 0.
- Response: rvalid_o=1 exactly one cycle after every gnt_o (fixed latency 1). No backpressure; the initiator must accept.
  - Read OK: rdata_o=sram_rdata_i, err_o=0.
  - Write OK: rdata_o=0, err_o=0.
  - Error: rdata_o=ErrData, err_o=1.
  - rdata_o=0 and err_o=0 whenever rvalid_o=0.
- Pipelining: a new grant may occur in the same cycle rvalid_o is high for the previous one. With WaitCycles=0, throughput is one transfer per cycle.
- WaitCycles>0: each request pays WaitCycles cycles before its grant, counted from the first req_i cycle in IDLE. Back-to-back requests each re-enter WAIT.
- Reset mid-operation: any pending response is dropped (rvalid_o goes low asynchronously). No SRAM access occurs while rst_ni is low.

Test Plan:
- WaitCycles=0, write 32'hDEAD_BEEF be=4'hF to 32'h1000_0010, then read the same address → gnt in the req cycle; sram_addr_o=4. Write response: rvalid, err=0, rdata=0. Read response one cycle after its grant: rdata=32'hDEAD_BEEF.
- Byte write be=4'b0010, wdata=32'h0000_AB00, to a word holding 32'h1122_3344; then read → rdata=32'h1122_AB44.
- Out-of-range read at 32'h1000_0800 (NumWords=512) and read at 32'h0FFF_FFFC → no sram_req_o; rvalid one cycle after gnt with err_o=1, rdata=32'hBADC_AB1E.
- be_i=0 write in range → no sram_req_o; err_o=1.
- WaitCycles=3, req_i held high → gnt_o on the 4th cycle of req; rvalid on the 5th. Then 4 back-to-back reads at WaitCycles=0 → 4 consecutive gnts and 4 consecutive rvalids with correct data in order.
- Assert rst_ni low in the cycle after a grant → rvalid_o and all outputs are 0 immediately. After release, the next read behaves normally with no stale response.
